guess_entry: RTL and testbench



---
 rtl/guess_entry.sv | 135 +++++++++++++
 tb/tb_guess_entry.sv | 133 +++++++++++++
 2 files changed

// File: rtl/guess_entry.sv
// guess_entry: collects three keypad digits and commits them as a triple with a one-cycle strobe.
// Optional build macro GUESS_DUP_CHECK_EN rejects a digit that is already staged.
`default_nettype none

module guess_entry #(
  parameter int unsigned TIMEOUT = 100000000,
  parameter int unsigned TO_W    = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] oNum1,
  output logic [3:0] oNum2,
  output logic [3:0] oNum3,
  output logic       oNumRdy,
  output logic [1:0] digit_cnt,
  output logic       key_err
);

  typedef enum logic [0:0] {
    ST_ENTRY = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t          state_q;
  logic [3:0]      s1_q, s2_q, s3_q;
  logic [TO_W-1:0] to_q;
  logic            dup_d;
  logic            to_hit_d;

  always_comb begin
    dup_d = 1'b0;
`ifdef GUESS_DUP_CHECK_EN
    // Only occupied slots count; empty slots hold 0, which is also a legal digit.
    if ((digit_cnt >= 2'd1) && (s1_q == key_code)) dup_d = 1'b1;
    if ((digit_cnt >= 2'd2) && (s2_q == key_code)) dup_d = 1'b1;
`endif
    to_hit_d = (TIMEOUT != 0) && (digit_cnt != 2'd0) && (to_q == C_TO_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_ENTRY;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      to_q      <= '0;
      oNum1     <= '0;
      oNum2     <= '0;
      oNum3     <= '0;
      oNumRdy   <= 1'b0;
      digit_cnt <= '0;
      key_err   <= 1'b0;
    end else begin
      key_err <= 1'b0;
      oNumRdy <= 1'b0;
      case (state_q)
        ST_ISSUE: begin
          state_q <= ST_ENTRY;
          to_q    <= '0;
        end
        default: begin
          if (key_valid) begin
            to_q <= '0;
            if (key_code <= 4'd9) begin
              if ((digit_cnt == 2'd3) || dup_d) begin
                key_err <= 1'b1;
              end else begin
                case (digit_cnt)
                  2'd0:    s1_q <= key_code;
                  2'd1:    s2_q <= key_code;
                  default: s3_q <= key_code;
                endcase
                digit_cnt <= digit_cnt + 2'd1;
              end
            end else begin
              case (key_code)
                4'hA: begin
                  if (digit_cnt == 2'd0) begin
                    key_err <= 1'b1;
                  end else begin
                    case (digit_cnt)
                      2'd1:    s1_q <= '0;
                      2'd2:    s2_q <= '0;
                      default: s3_q <= '0;
                    endcase
                    digit_cnt <= digit_cnt - 2'd1;
                  end
                end
                4'hB: begin
                  s1_q      <= '0;
                  s2_q      <= '0;
                  s3_q      <= '0;
                  digit_cnt <= '0;
                end
                4'hE: begin
                  if (digit_cnt == 2'd3) begin
                    oNum1     <= s1_q;
                    oNum2     <= s2_q;
                    oNum3     <= s3_q;
                    s1_q      <= '0;
                    s2_q      <= '0;
                    s3_q      <= '0;
                    digit_cnt <= '0;
                    oNumRdy   <= 1'b1;
                    state_q   <= ST_ISSUE;
                  end else begin
                    key_err <= 1'b1;
                  end
                end
                default: key_err <= 1'b1;
              endcase
            end
          end else if (to_hit_d) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            digit_cnt <= '0;
            to_q      <= '0;
          end else if ((digit_cnt == 2'd0) || (TIMEOUT == 0)) begin
            to_q <= '0;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_guess_entry.sv
// Directed self-checking bench for guess_entry, built with TIMEOUT=16.
`default_nettype none

module tb_guess_entry;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] oNum1, oNum2, oNum3;
  logic       oNumRdy;
  logic [1:0] digit_cnt;
  logic       key_err;

  int checks = 0;
  int errors = 0;

  guess_entry #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .oNum1(oNum1), .oNum2(oNum2), .oNum3(oNum3), .oNumRdy(oNumRdy),
    .digit_cnt(digit_cnt), .key_err(key_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One idle cycle, then a one-cycle key strobe; returns just after the accepting edge.
  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [11:0] num, input logic rdy,
                         input logic [1:0] cnt, input logic err);
    chk({tag, "_num"}, {4'h0, oNum1, oNum2, oNum3}, {4'h0, num});
    chk({tag, "_rdy"}, {15'h0, oNumRdy}, {15'h0, rdy});
    chk({tag, "_cnt"}, {14'h0, digit_cnt}, {14'h0, cnt});
    chk({tag, "_err"}, {15'h0, key_err}, {15'h0, err});
  endtask

  initial begin
    #12;
    chk_all("reset", 12'h000, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    press(4'd1); press(4'd2); press(4'd3);
    chk("cnt3", {14'h0, digit_cnt}, 16'd3);
    press(4'hE);
    chk_all("commit123", 12'h123, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    chk_all("after123", 12'h123, 1'b0, 2'd0, 1'b0);

    press(4'd4); press(4'd5); press(4'hA);
    chk("bs_cnt", {14'h0, digit_cnt}, 16'd1);
    press(4'd6);
    press(4'hE);
    chk_all("short_enter", 12'h123, 1'b0, 2'd2, 1'b1);
    @(negedge clk);
    chk("err_one_cycle", {15'h0, key_err}, 16'd0);
    press(4'd9);
    press(4'hE);
    chk_all("commit469", 12'h469, 1'b1, 2'd0, 1'b0);

    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk_all("fourth_digit", 12'h469, 1'b0, 2'd3, 1'b1);
    press(4'hE);
    chk_all("commit123b", 12'h123, 1'b1, 2'd0, 1'b0);

    // Key presented during the ISSUE cycle must be ignored silently.
    key_valid = 1'b1;
    key_code  = 4'd5;
    @(negedge clk);
    key_valid = 1'b0;
    chk_all("issue_ignore", 12'h123, 1'b0, 2'd0, 1'b0);

    press(4'hA);
    chk_all("bs_empty", 12'h123, 1'b0, 2'd0, 1'b1);
    press(4'hC);
    chk_all("illegal", 12'h123, 1'b0, 2'd0, 1'b1);
    press(4'd7); press(4'd8);
    press(4'hB);
    chk_all("clear", 12'h123, 1'b0, 2'd0, 1'b0);

    press(4'd8);
    repeat (15) @(negedge clk);
    chk("to_before", {14'h0, digit_cnt}, 16'd1);
    @(negedge clk);
    chk_all("to_fire", 12'h123, 1'b0, 2'd0, 1'b0);

    press(4'd8);
    repeat (14) @(negedge clk);
    press(4'd9);
    chk_all("to_keywins", 12'h123, 1'b0, 2'd2, 1'b0);
    press(4'hB);

`ifdef GUESS_DUP_CHECK_EN
    press(4'd3); press(4'd3);
    chk_all("dup_reject", 12'h123, 1'b0, 2'd1, 1'b1);
    press(4'hB);
`else
    press(4'd3); press(4'd3); press(4'd3); press(4'hE);
    chk_all("dup_accept", 12'h333, 1'b1, 2'd0, 1'b0);
`endif

    press(4'd1); press(4'd2);
    #2 reset = 1'b0;
    #1 chk_all("rst_mid", 12'h000, 1'b0, 2'd0, 1'b0);
    #1 reset = 1'b1;
    press(4'd5); press(4'd6); press(4'd7); press(4'hE);
    chk_all("commit567", 12'h567, 1'b1, 2'd0, 1'b0);
    #2 reset = 1'b0;
    #1 chk_all("rst_issue", 12'h000, 1'b0, 2'd0, 1'b0);
    #1 reset = 1'b1;
    press(4'd2); press(4'd0); press(4'd8); press(4'hE);
    chk_all("commit208", 12'h208, 1'b1, 2'd0, 1'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
